stack_matrix_driver: RTL and testbench

- Display-side consumer of the stacker game engine's line output: captures each line pattern (lineDisplay) by line number into a frame buffer.
- Time-multiplexes the buffer onto an 8x8 row-scanned LED matrix, with per-row blanking.
- Flashes the whole stack after end-of-game until cleared.
- Sits between the game engine and the board LED matrix pins.

---
 rtl/stack_matrix_driver.sv | 151 +++++++++++++++
 tb/tb_stack_matrix_driver.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/stack_matrix_driver.sv
`default_nettype none
// ============================================================================
// stack_matrix_driver : line frame buffer + row-scanned 8x8 LED matrix driver
//                       with end-of-game flashing.  Rev 1.0
// ============================================================================
module stack_matrix_driver #(
  parameter int ROWS         = 8,
  parameter int COLS         = 8,
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYC    = 16,
  parameter int FLASH_FRAMES = 32
) (
  input  logic                    clk,
  input  logic                    rstBtn,
  input  logic                    wrEn,
  input  logic [$clog2(ROWS)-1:0] lineNum,
  input  logic [COLS-1:0]         lineDisplay,
  input  logic                    EOG,
  input  logic                    clrAll,
  output logic [ROWS-1:0]         rowSel,
  output logic [COLS-1:0]         colData,
  output logic                    frameTick
);

  localparam int LW = $clog2(ROWS);
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
  localparam logic [DW-1:0] C_DIV_LAST   = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] C_BLANK_END  = DW'(BLANK_CYC);
  localparam logic [LW-1:0] C_ROW_LAST   = LW'(ROWS - 1);
  localparam logic [FW-1:0] C_FLASH_LAST = FW'(FLASH_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_NORMAL    = 2'd0,
    ST_FLASH_ON  = 2'd1,
    ST_FLASH_OFF = 2'd2
  } state_t;

  logic [DW-1:0]   divCnt_q;
  logic [LW-1:0]   rowIdx_q;
  logic [COLS-1:0] lineBuf_q [ROWS];
  state_t          state_q, state_d;
  logic [FW-1:0]   flashCnt_q, flashCnt_d;
  logic            eog_q;
  logic [ROWS-1:0] rowSel_q, rowSel_d;
  logic [COLS-1:0] colData_q, colData_d;
  logic            frameTick_q;

  logic w_slotEnd, w_frameWrap, w_eogRise, w_lineOk;

  assign w_slotEnd   = (divCnt_q == C_DIV_LAST);
  assign w_frameWrap = w_slotEnd && (rowIdx_q == C_ROW_LAST);
  assign w_eogRise   = EOG && !eog_q;

  // Out-of-range line numbers only exist when ROWS is not a power of two.
  if ((1 << LW) == ROWS) begin : g_pow2
    assign w_lineOk = 1'b1;
  end else begin : g_npow2
    assign w_lineOk = (32'(lineNum) < ROWS);
  end

  always_ff @(posedge clk) begin
    if (rstBtn) begin
      divCnt_q <= '0;
      rowIdx_q <= '0;
    end else begin
      divCnt_q <= w_slotEnd ? '0 : divCnt_q + DW'(1);
      if (w_slotEnd) rowIdx_q <= (rowIdx_q == C_ROW_LAST) ? '0 : rowIdx_q + LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rstBtn || clrAll) begin
      for (int r = 0; r < ROWS; r++) lineBuf_q[r] <= '0;
    end else if (wrEn && w_lineOk) begin
      lineBuf_q[lineNum] <= lineDisplay;
    end
  end

  always_ff @(posedge clk) begin
    if (rstBtn) begin
      state_q    <= ST_NORMAL;
      flashCnt_q <= '0;
      eog_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      flashCnt_q <= flashCnt_d;
      eog_q      <= EOG;
    end
  end

  always_comb begin
    state_d    = state_q;
    flashCnt_d = flashCnt_q;
    if (clrAll) begin
      state_d    = ST_NORMAL;
      flashCnt_d = '0;
    end else begin
      case (state_q)
        ST_NORMAL: begin
          if (w_eogRise) begin
            state_d    = ST_FLASH_ON;
            flashCnt_d = '0;
          end
        end
        ST_FLASH_ON, ST_FLASH_OFF: begin
          if (w_frameWrap) begin
            if (flashCnt_q == C_FLASH_LAST) begin
              flashCnt_d = '0;
              state_d    = (state_q == ST_FLASH_ON) ? ST_FLASH_OFF : ST_FLASH_ON;
            end else begin
              flashCnt_d = flashCnt_q + FW'(1);
            end
          end
        end
        default: begin
          state_d    = ST_NORMAL;
          flashCnt_d = '0;
        end
      endcase
    end
  end

  // Row still scans in the dark flash phase so duty cycle stays constant.
  always_comb begin
    rowSel_d  = '0;
    colData_d = '0;
    if (divCnt_q >= C_BLANK_END) begin
      rowSel_d[rowIdx_q] = 1'b1;
      if (state_q != ST_FLASH_OFF) colData_d = lineBuf_q[rowIdx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rstBtn) begin
      rowSel_q    <= '0;
      colData_q   <= '0;
      frameTick_q <= 1'b0;
    end else begin
      rowSel_q    <= rowSel_d;
      colData_q   <= colData_d;
      frameTick_q <= w_frameWrap;
    end
  end

  assign rowSel    = rowSel_q;
  assign colData   = colData_q;
  assign frameTick = frameTick_q;

endmodule
`default_nettype wire

// File: tb/tb_stack_matrix_driver.sv
`default_nettype none
// ============================================================================
// tb_stack_matrix_driver : directed self-checking bench (SCAN_DIV=4,
//                          BLANK_CYC=1, FLASH_FRAMES=2, 8x8). Rev 1.0
// ============================================================================
module tb_stack_matrix_driver;

  logic       clk = 1'b0;
  logic       rstBtn, wrEn, EOG, clrAll;
  logic [2:0] lineNum;
  logic [7:0] lineDisplay;
  logic [7:0] rowSel, colData;
  logic       frameTick;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int e0    = 0;
  bit flashing = 1'b0;
  logic [7:0] mem [8];

  stack_matrix_driver #(
    .ROWS(8), .COLS(8), .SCAN_DIV(4), .BLANK_CYC(1), .FLASH_FRAMES(2)
  ) dut (
    .clk(clk), .rstBtn(rstBtn), .wrEn(wrEn), .lineNum(lineNum),
    .lineDisplay(lineDisplay), .EOG(EOG), .clrAll(clrAll),
    .rowSel(rowSel), .colData(colData), .frameTick(frameTick)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Expected {rowSel,colData,frameTick} after edge number cyc since release.
  task automatic chkScan(input string tag);
    int c;
    logic [7:0] er, ec;
    bit dark;
    c    = (cyc - 1) % 32;
    er   = (c % 4 == 0) ? 8'h00 : 8'(1 << (c / 4));
    dark = flashing && ((((cyc - e0) / 64) % 2) == 1);
    ec   = (er == 8'h00 || dark) ? 8'h00 : mem[c / 4];
    chk(tag, {15'd0, rowSel, colData, frameTick}, {15'd0, er, ec, (cyc % 32 == 0)});
  endtask

  task automatic wrLine(input logic [2:0] n, input logic [7:0] d);
    wrEn = 1'b1; lineNum = n; lineDisplay = d;
    tick();
    chkScan("wr_edge");
    mem[n] = d;
    wrEn = 1'b0;
  endtask

  task automatic alignTo(input int m);
    for (int i = 0; i < 64 && (cyc % 32) != m; i++) begin
      tick();
      chkScan("align");
    end
  endtask

  initial begin
    for (int r = 0; r < 8; r++) mem[r] = 8'h00;
    rstBtn = 1'b1; wrEn = 1'b0; EOG = 1'b0; clrAll = 1'b0;
    lineNum = 3'd0; lineDisplay = 8'h00;

    // 1: reset, then one clean frame of scanning
    tick(); tick();
    chk("rst_rowSel", {24'd0, rowSel}, 32'h00);
    chk("rst_colData", {24'd0, colData}, 32'h00);
    chk("rst_frameTick", {31'd0, frameTick}, 32'h0);
    rstBtn = 1'b0;
    cyc = 0;
    tick();
    chk("first_blank", {24'd0, rowSel}, 32'h00);
    tick();
    chk("first_row0", {16'd0, rowSel, colData}, 32'h0100);
    for (int i = 0; i < 31; i++) begin tick(); chkScan("scan0"); end

    // 2: two line writes, then a full frame showing them
    wrLine(3'd0, 8'h1C);
    wrLine(3'd1, 8'h38);
    for (int i = 0; i < 32; i++) begin tick(); chkScan("frame_data"); end

    // 3: write into the row currently being shown
    alignTo(13);
    wrLine(3'd3, 8'hF0);
    chk("wr_live_old", {16'd0, rowSel, colData}, 32'h0800);
    tick();
    chk("wr_live_new", {16'd0, rowSel, colData}, 32'h08F0);

    // 4 + 5: EOG flashing, stray EOG pulses, then clear+write during FLASH_ON
    alignTo(0);
    EOG = 1'b1;
    tick();
    chkScan("eog_edge");
    EOG = 1'b0;
    e0 = cyc;
    flashing = 1'b1;
    for (int p = 1; p <= 290; p++) begin
      EOG = (p == 40 || p == 100);
      if (p == 271) begin
        clrAll = 1'b1; wrEn = 1'b1; lineNum = 3'd2; lineDisplay = 8'hFF;
      end
      tick();
      chkScan("flash");
      if (p == 271) begin
        clrAll = 1'b0; wrEn = 1'b0;
        for (int r = 0; r < 8; r++) mem[r] = 8'h00;
        flashing = 1'b0;
      end
    end
    EOG = 1'b0;

    // After clear the FSM must be NORMAL: a fresh pattern stays lit > 2 frames
    wrLine(3'd0, 8'hAA);
    for (int i = 0; i < 70; i++) begin tick(); chkScan("post_clr"); end

    alignTo(0);
    EOG = 1'b1;
    tick();
    chkScan("eog2_edge");
    EOG = 1'b0;
    e0 = cyc;
    flashing = 1'b1;
    for (int p = 1; p <= 130; p++) begin tick(); chkScan("reflash"); end

    // 6: reset in the middle of row 4, scan restarts, pattern lost
    alignTo(19);
    chk("pre_rst_row4", {24'd0, rowSel}, 32'h10);
    rstBtn = 1'b1;
    tick();
    chk("mid_rst", {15'd0, rowSel, colData, frameTick}, 32'h0);
    rstBtn = 1'b0;
    cyc = 0;
    flashing = 1'b0;
    for (int r = 0; r < 8; r++) mem[r] = 8'h00;
    for (int i = 0; i < 34; i++) begin tick(); chkScan("after_rst"); end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
